// File: rtl/delay_line_multi_pkg.sv
// Shared definitions for the multi-channel delay line.
//   state_t   : control FSM encoding (ST_FILL = blanking, ST_RUN = delayed data on out)
//   DELAY_MIN : smallest delay the block will run with; a requested delay of 0 is raised to this
package delay_line_multi_pkg;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DELAY_MIN = 1;

endpackage

// File: rtl/delay_line_multi_ring.sv
// DEPTH x WIDTH simple dual-port sample store with synchronous write and registered read.
// No reset, so it can map onto block RAM.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : registered read data
module delay_line_multi_ring #(
  parameter int  DEPTH = 256,
  parameter int  WIDTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: store the incoming sample
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: write-first on an address collision, which only happens at delay 1
  always_ff @(posedge clk) begin
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/delay_line_multi.sv
// Multi-channel runtime-programmable delay line. Every channel is delayed by the same
// number of clk cycles using a circular buffer; out is blanked to IDLE_LEVEL until the
// buffer holds enough samples for the current delay.
// Optional build macro: DELAY_LINE_SYNC_EN adds a 2-flop synchroniser per channel in front
// of the buffer (latency D+2, blanking length still D).
// Ports:
//   clk       : system clock
//   n_reset   : asynchronous active-low reset
//   in        : CHANNELS input signals, sampled every rising clk
//   out       : CHANNELS delayed signals (IDLE_LEVEL while blanked)
//   cfg_delay : requested delay in cycles
//   cfg_valid : cfg_delay is valid
//   cfg_ready : a config word can be accepted (high in RUN)
//   cfg_err   : one-cycle pulse after an accepted cfg_delay was clamped
//   running   : out carries delayed data
module delay_line_multi #(
  parameter int   CHANNELS      = 4,
  parameter int   DEPTH         = 256,
  parameter int   DEFAULT_DELAY = 16,
  parameter logic IDLE_LEVEL    = 1'b0,
  localparam int  PW            = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  input  logic [PW-1:0]       cfg_delay,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic                cfg_err,
  output logic                running
);
  import delay_line_multi_pkg::*;

  localparam logic [PW-1:0] ZERO      = {PW{1'b0}};
  localparam logic [PW-1:0] ONE       = PW'(1);
  localparam logic [PW-1:0] DEF_DELAY = PW'(DEFAULT_DELAY);
  localparam logic [PW-1:0] MIN_DELAY = PW'(DELAY_MIN);

  state_t              state_r;
  state_t              state_next_s;
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       delay_r;
  logic [PW-1:0]       delay_next_s;
  logic [PW-1:0]       fill_cnt_r;
  logic [PW-1:0]       fill_next_s;
  logic                cfg_err_next_s;
  logic [PW-1:0]       raddr_s;
  logic [CHANNELS-1:0] wdata_s;
  logic [CHANNELS-1:0] rdata_s;

`ifdef DELAY_LINE_SYNC_EN
  logic [CHANNELS-1:0] sync1_r;
  logic [CHANNELS-1:0] sync2_r;

  // Two-flop synchroniser per channel ahead of the buffer
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1_r <= {CHANNELS{IDLE_LEVEL}};
      sync2_r <= {CHANNELS{IDLE_LEVEL}};
    end else begin
      sync1_r <= in;
      sync2_r <= sync1_r;
    end
  end

  assign wdata_s = sync2_r;
`else
  assign wdata_s = in;
`endif

  // Write pointer advances every cycle and wraps naturally at DEPTH
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_r <= ZERO;
    end else begin
      wr_ptr_r <= wr_ptr_r + ONE;
    end
  end

  // The +1 compensates for the registered read so a sample shows on out exactly D cycles later
  assign raddr_s = wr_ptr_r - delay_r + ONE;

  delay_line_multi_ring #(
    .DEPTH (DEPTH),
    .WIDTH (CHANNELS)
  ) u_ring (
    .clk   (clk),
    .we    (1'b1),
    .waddr (wr_ptr_r),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Next-state logic: blank for D cycles in FILL, accept config words only in RUN
  always_comb begin
    state_next_s   = state_r;
    delay_next_s   = delay_r;
    fill_next_s    = fill_cnt_r + ONE;
    cfg_err_next_s = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (fill_cnt_r == (delay_r - ONE)) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_RUN: begin
        if (cfg_valid) begin
          // Any accepted word re-enters FILL, even an unchanged delay
          state_next_s = ST_FILL;
          fill_next_s  = ZERO;
          if (cfg_delay == ZERO) begin
            delay_next_s   = MIN_DELAY;
            cfg_err_next_s = 1'b1;
          end else begin
            delay_next_s = cfg_delay;
          end
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_FILL;
        fill_next_s  = ZERO;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r    <= ST_FILL;
      delay_r    <= DEF_DELAY;
      fill_cnt_r <= ZERO;
      cfg_err    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      delay_r    <= delay_next_s;
      fill_cnt_r <= fill_next_s;
      cfg_err    <= cfg_err_next_s;
    end
  end

  assign running   = (state_r == ST_RUN);
  assign cfg_ready = running;
  assign out       = running ? rdata_s : {CHANNELS{IDLE_LEVEL}};

endmodule

// File: tb/tb_delay_line_multi.sv
// Self-checking bench for delay_line_multi (CHANNELS=4, DEPTH=256, DEFAULT_DELAY=16).
// Honours DELAY_LINE_SYNC_EN: expected data latency grows by 2 cycles when it is defined.
module tb_delay_line_multi;

`ifdef DELAY_LINE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int NEVER = 32'h3fff_ffff;
  localparam int HMAX  = 8192;

  logic       clk;
  logic       n_reset;
  logic [3:0] din;
  logic [3:0] dout;
  logic [7:0] cfg_delay;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_err;
  logic       running;

  delay_line_multi #(
    .CHANNELS      (4),
    .DEPTH         (256),
    .DEFAULT_DELAY (16),
    .IDLE_LEVEL    (1'b0)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .in        (din),
    .out       (dout),
    .cfg_delay (cfg_delay),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .running   (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] cfg;        // word presented on cfg_delay
    int         eff;        // delay expected to take effect
    logic       err;        // expected cfg_err pulse
    int         run_cycles; // cycles of random traffic checked afterwards
  } vec_t;

  int         checks;
  int         errors;
  int         cyc;
  int         run_from;
  int         cur_d;
  int         err_cyc;
  logic [3:0] hist [HMAX];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, expv);
    end
  endtask

  // One clock: log the input driven this interval, advance, check the new interval
  task automatic tick();
    logic       exp_run;
    logic [3:0] exp_out;
    int         src;
    if (cyc < HMAX) hist[cyc] = din;
    @(posedge clk);
    #1;
    cyc++;
    exp_run = (cyc >= run_from);
    exp_out = 4'b0000;
    if (exp_run) begin
      src = cyc - cur_d - SL;
      if (src >= 0 && src < HMAX) exp_out = hist[src];
    end
    chk("out", int'(dout), int'(exp_out));
    chk("running", int'(running), int'(exp_run));
    chk("cfg_ready", int'(cfg_ready), int'(exp_run));
    chk("cfg_err", int'(cfg_err), (cyc == err_cyc) ? 1 : 0);
  endtask

  task automatic rand_tick();
    din = 4'($urandom_range(0, 15));
    tick();
  endtask

  // Asynchronous reset: outputs must drop before any clock edge
  task automatic apply_reset();
    din       = 4'b0000;
    cfg_valid = 1'b0;
    n_reset   = 1'b0;
    run_from  = NEVER;
    err_cyc   = -1;
    cur_d     = 16;
    #2;
    chk("rst_out", int'(dout), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    repeat (3) tick();
    n_reset  = 1'b1;
    run_from = cyc + 16;
  endtask

  // Present one config word in a RUN interval; accepted on the next edge
  task automatic cfg_write(input logic [7:0] d, input int eff, input logic err);
    cfg_delay = d;
    cfg_valid = 1'b1;
    cur_d     = eff;
    run_from  = cyc + 1 + eff;
    err_cyc   = err ? cyc + 1 : -1;
    din       = 4'($urandom_range(0, 15));
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    vec_t tbl [6];
    int   c0;
    int   pos;
    int   ones;
    int   n;

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    run_from  = NEVER;
    cur_d     = 16;
    err_cyc   = -1;
    din       = 4'b0000;
    cfg_delay = 8'd0;
    cfg_valid = 1'b0;
    n_reset   = 1'b1;
    for (int i = 0; i < HMAX; i++) hist[i] = 4'b0000;

    tbl[0] = '{cfg: 8'd5,   eff: 5,   err: 1'b0, run_cycles: 30};
    tbl[1] = '{cfg: 8'd0,   eff: 1,   err: 1'b1, run_cycles: 20};
    tbl[2] = '{cfg: 8'd1,   eff: 1,   err: 1'b0, run_cycles: 10};
    tbl[3] = '{cfg: 8'd255, eff: 255, err: 1'b0, run_cycles: 2000};
    tbl[4] = '{cfg: 8'd16,  eff: 16,  err: 1'b0, run_cycles: 40};
    tbl[5] = '{cfg: 8'd16,  eff: 16,  err: 1'b0, run_cycles: 40};

    #1;
    apply_reset();

    // Single-cycle pulse at relative cycle 20 with the default delay of 16
    c0   = cyc;
    pos  = -1;
    ones = 0;
    for (int i = 0; i < 60; i++) begin
      din = (cyc - c0 == 20) ? 4'b0001 : 4'b0000;
      tick();
      if (dout == 4'b0001) begin
        pos = cyc - c0;
        ones++;
      end
    end
    chk("pulse_pos", pos, 36 + SL);
    chk("pulse_count", ones, 1);

    // Reconfiguration table, including a clamp, delay 1, max delay and a repeated delay
    for (int i = 0; i < 6; i++) begin
      cfg_write(tbl[i].cfg, tbl[i].eff, tbl[i].err);
      n = 0;
      while (!running && n < 300) begin
        n++;
        rand_tick();
      end
      chk("blank_len", n, tbl[i].eff);
      repeat (tbl[i].run_cycles) rand_tick();
    end

    // cfg_valid held through FILL must be taken once, on the first RUN cycle
    cfg_write(8'd8, 8, 1'b0);
    cfg_delay = 8'd3;
    cfg_valid = 1'b1;
    while (cyc < run_from) rand_tick();
    chk("held_ready", int'(cfg_ready), 1);
    cur_d    = 3;
    run_from = cyc + 1 + 3;
    rand_tick();
    cfg_valid = 1'b0;
    n = 0;
    while (!running && n < 300) begin
      n++;
      rand_tick();
    end
    chk("held_blank_len", n, 3);
    repeat (20) rand_tick();

    // Reset in the middle of a long FILL restores the default delay
    cfg_write(8'd100, 100, 1'b0);
    repeat (40) rand_tick();
    apply_reset();
    n = 0;
    while (!running && n < 300) begin
      n++;
      rand_tick();
    end
    chk("rst_blank_len", n, 16);
    repeat (40) rand_tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
